// File: rtl/t07_mmio_sequencer.sv
// t07_mmio_sequencer: turns one memory-handler request (write/read/fetch)
// into a single bus cycle, then reports completion to the handler with one
// falling edge on busy_o.
// Optional feature: define T07_MMIO_TIMEOUT_EN to abort a bus cycle that goes
// unacknowledged for TIMEOUT_CYCLES clocks. An aborted cycle returns DEADVAL
// as its data and sets a sticky timeout_o flag that only reset clears.
module t07_mmio_sequencer #(
  parameter int unsigned TIMEOUT_CYCLES = 64,
  parameter logic [31:0] DEADVAL        = 32'hDEADBEEF
) (
  input  logic        clk,
  input  logic        rst,
  input  logic [1:0]  rwi_i,
  input  logic [31:0] addr_i,
  input  logic [31:0] wdata_i,
  output logic        busy_o,
  output logic [31:0] rdata_o,
  output logic [31:0] instr_o,
  output logic        bus_cyc_o,
  output logic        bus_we_o,
  output logic [31:0] bus_adr_o,
  output logic [31:0] bus_dat_o,
  output logic [3:0]  bus_sel_o,
  input  logic [31:0] bus_dat_i,
  input  logic        bus_ack_i,
  output logic        timeout_o
);

  localparam logic [1:0] IDLE = 2'd0;
  localparam logic [1:0] BUS  = 2'd1;
  localparam logic [1:0] DONE = 2'd2;

  localparam logic [1:0] KIND_WRITE = 2'b01;
  localparam logic [1:0] KIND_READ  = 2'b10;
  localparam logic [1:0] KIND_FETCH = 2'b11;

`ifdef T07_MMIO_TIMEOUT_EN
  localparam bit TIMEOUT_EN = 1'b1;
`else
  localparam bit TIMEOUT_EN = 1'b0;
`endif

  // The wait counter holds BUS cycles already spent without ack. The cycle
  // in which it reaches TIMEOUT_CYCLES-1 is the last BUS cycle allowed.
  localparam int unsigned     CNT_W    = $clog2(TIMEOUT_CYCLES + 1);
  localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(TIMEOUT_CYCLES - 1);

  logic [1:0]       state_q, state_d;
  logic [31:0]      addr_q, addr_d;
  logic [31:0]      wdata_q, wdata_d;
  logic             we_q, we_d;
  logic [1:0]       kind_q, kind_d;
  logic [31:0]      rdata_q, rdata_d;
  logic [31:0]      instr_q, instr_d;
  logic [CNT_W-1:0] cnt_q, cnt_d;
  logic             timeout_q, timeout_d;

  logic        inBus;
  logic        expire;
  logic        cycleEnd;
  logic [31:0] loadVal;

  // An ack in the expiry cycle takes priority, so expiry only counts when
  // ack is absent. When the timeout feature is off, expire is constant 0 and
  // the counter has no effect on the outputs.
  assign inBus    = (state_q == BUS);
  assign expire   = TIMEOUT_EN && inBus && !bus_ack_i && (cnt_q == CNT_LAST);
  assign cycleEnd = inBus && (bus_ack_i || expire);
  assign loadVal  = bus_ack_i ? bus_dat_i : DEADVAL;

  // Next-state logic: accept a request in IDLE, wait for ack (or expiry) in
  // BUS, and spend exactly one DONE cycle before taking the next request.
  always_comb begin
    state_d   = state_q;
    addr_d    = addr_q;
    wdata_d   = wdata_q;
    we_d      = we_q;
    kind_d    = kind_q;
    rdata_d   = rdata_q;
    instr_d   = instr_q;
    cnt_d     = cnt_q;
    timeout_d = timeout_q;
    case (state_q)
      IDLE: begin
        if (rwi_i != 2'b00) begin
          addr_d  = addr_i;
          wdata_d = wdata_i;
          we_d    = (rwi_i == KIND_WRITE);
          kind_d  = rwi_i;
          cnt_d   = '0;
          state_d = BUS;
        end
      end
      BUS: begin
        if (cycleEnd) begin
          state_d = DONE;
          if (kind_q == KIND_READ) begin
            rdata_d = loadVal;
          end
          if (kind_q == KIND_FETCH) begin
            instr_d = loadVal;
          end
          if (expire) begin
            timeout_d = 1'b1;
          end
        end else begin
          cnt_d = cnt_q + CNT_W'(1);
        end
      end
      DONE: begin
        state_d = IDLE;
      end
      default: begin
        state_d = IDLE;
      end
    endcase
  end

  // State and data registers with synchronous active-high reset.
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q   <= IDLE;
      addr_q    <= '0;
      wdata_q   <= '0;
      we_q      <= 1'b0;
      kind_q    <= 2'b00;
      rdata_q   <= '0;
      instr_q   <= '0;
      cnt_q     <= '0;
      timeout_q <= 1'b0;
    end else begin
      state_q   <= state_d;
      addr_q    <= addr_d;
      wdata_q   <= wdata_d;
      we_q      <= we_d;
      kind_q    <= kind_d;
      rdata_q   <= rdata_d;
      instr_q   <= instr_d;
      cnt_q     <= cnt_d;
      timeout_q <= timeout_d;
    end
  end

  // Bus outputs come only from latched values while in BUS and are zero
  // otherwise, so input changes never disturb a cycle in flight.
  assign busy_o    = inBus;
  assign bus_cyc_o = inBus;
  assign bus_we_o  = inBus && we_q;
  assign bus_adr_o = inBus ? addr_q : 32'h0;
  assign bus_dat_o = inBus ? wdata_q : 32'h0;
  assign bus_sel_o = 4'b1111;
  assign rdata_o   = rdata_q;
  assign instr_o   = instr_q;
  assign timeout_o = TIMEOUT_EN && timeout_q;

endmodule

// File: tb/tb_t07_mmio_sequencer.sv
// tb_t07_mmio_sequencer: directed and randomized transactions for
// t07_mmio_sequencer. Expected results come from a transaction-level model:
// the data each transaction should return, and how many busy falling edges and
// completed writes it should cause. When T07_MMIO_TIMEOUT_EN is defined, the
// timeout section runs as well.
module tb_t07_mmio_sequencer;

  localparam int unsigned TO_CYCLES = 8;

  logic        clk = 1'b0;
  logic        rst;
  logic [1:0]  rwi_i;
  logic [31:0] addr_i;
  logic [31:0] wdata_i;
  logic        busy_o;
  logic [31:0] rdata_o;
  logic [31:0] instr_o;
  logic        bus_cyc_o;
  logic        bus_we_o;
  logic [31:0] bus_adr_o;
  logic [31:0] bus_dat_o;
  logic [3:0]  bus_sel_o;
  logic [31:0] bus_dat_i;
  logic        bus_ack_i;
  logic        timeout_o;

  int checks   = 0;
  int failures = 0;

  int   fallCount  = 0;
  int   writeCount = 0;
  logic busyPrev   = 1'b0;

  logic [31:0] expRdata;
  logic [31:0] expInstr;
  logic        expTimeout;

  t07_mmio_sequencer #(
    .TIMEOUT_CYCLES(TO_CYCLES),
    .DEADVAL       (32'hDEADBEEF)
  ) dut (
    .clk      (clk),
    .rst      (rst),
    .rwi_i    (rwi_i),
    .addr_i   (addr_i),
    .wdata_i  (wdata_i),
    .busy_o   (busy_o),
    .rdata_o  (rdata_o),
    .instr_o  (instr_o),
    .bus_cyc_o(bus_cyc_o),
    .bus_we_o (bus_we_o),
    .bus_adr_o(bus_adr_o),
    .bus_dat_o(bus_dat_o),
    .bus_sel_o(bus_sel_o),
    .bus_dat_i(bus_dat_i),
    .bus_ack_i(bus_ack_i),
    .timeout_o(timeout_o)
  );

  // Free-running clock, 10 time-unit period.
  always #5 clk = ~clk;

  // Away from the active edge, count busy falling edges and completed bus writes.
  always @(negedge clk) begin
    if (busyPrev && !busy_o) fallCount++;
    if (bus_cyc_o && bus_we_o && bus_ack_i) writeCount++;
    busyPrev = busy_o;
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic checkOutput(input string tag, input logic [31:0] observed,
                             input logic [31:0] expected);
    checks++;
    assert (observed === expected) else begin
      failures++;
      $error("[TB] FAIL %s observed=%h expected=%h", tag, observed, expected);
    end
  endtask

  task automatic applyStimulus(input logic [1:0] rwi, input logic [31:0] addr,
                               input logic [31:0] wdata, input logic ack,
                               input logic [31:0] dat);
    rwi_i     = rwi;
    addr_i    = addr;
    wdata_i   = wdata;
    bus_ack_i = ack;
    bus_dat_i = dat;
  endtask

  // Check the whole output set when no bus cycle is in flight.
  task automatic checkIdle(input string tag);
    checkOutput({tag, ".busy"},    32'(busy_o),    32'd0);
    checkOutput({tag, ".cyc"},     32'(bus_cyc_o), 32'd0);
    checkOutput({tag, ".we"},      32'(bus_we_o),  32'd0);
    checkOutput({tag, ".adr"},     bus_adr_o,      32'd0);
    checkOutput({tag, ".dat"},     bus_dat_o,      32'd0);
    checkOutput({tag, ".sel"},     32'(bus_sel_o), 32'hF);
    checkOutput({tag, ".rdata"},   rdata_o,        expRdata);
    checkOutput({tag, ".instr"},   instr_o,        expInstr);
    checkOutput({tag, ".timeout"}, 32'(timeout_o), 32'(expTimeout));
  endtask

  // Check the bus outputs during a bus cycle.
  task automatic checkBus(input string tag, input logic [31:0] addr,
                          input logic we, input logic [31:0] wdata);
    checkOutput({tag, ".busy"}, 32'(busy_o),    32'd1);
    checkOutput({tag, ".cyc"},  32'(bus_cyc_o), 32'd1);
    checkOutput({tag, ".we"},   32'(bus_we_o),  32'(we));
    checkOutput({tag, ".adr"},  bus_adr_o,      addr);
    checkOutput({tag, ".dat"},  bus_dat_o,      wdata);
    checkOutput({tag, ".sel"},  32'(bus_sel_o), 32'hF);
  endtask

  // One complete transaction: request, delay wait cycles with no ack, ack with
  // dat, one DONE cycle (with a stray ack), then back in IDLE.
  task automatic runTxn(input string tag, input logic [1:0] kind,
                        input logic [31:0] addr, input logic [31:0] wdata,
                        input int delay, input logic [31:0] dat);
    int f0;
    int w0;
    f0 = fallCount;
    w0 = writeCount;
    applyStimulus(kind, addr, wdata, 1'b0, $urandom);
    tick();
    checkBus({tag, ".bus"}, addr, kind == 2'b01, wdata);
    for (int i = 0; i < delay; i++) begin
      applyStimulus(2'($urandom), $urandom, $urandom, 1'b0, $urandom);
      tick();
      checkBus({tag, ".wait"}, addr, kind == 2'b01, wdata);
    end
    applyStimulus(2'b00, $urandom, $urandom, 1'b1, dat);
    tick();
    if (kind == 2'b10) expRdata = dat;
    if (kind == 2'b11) expInstr = dat;
    checkIdle({tag, ".done"});
    applyStimulus(2'b00, $urandom, $urandom, 1'b1, $urandom);
    tick();
    checkIdle({tag, ".idle"});
    checkOutput({tag, ".falls"},  32'(fallCount - f0),  32'd1);
    checkOutput({tag, ".writes"}, 32'(writeCount - w0), (kind == 2'b01) ? 32'd1 : 32'd0);
    applyStimulus(2'b00, 32'h0, 32'h0, 1'b0, 32'h0);
  endtask

  initial begin
    int          f0;
    int          w0;
    logic [1:0]  kind;
    logic [31:0] addr;
    logic [31:0] wdata;
    logic [31:0] dat;

    // Reset state.
    rst = 1'b1;
    applyStimulus(2'b00, 32'h0, 32'h0, 1'b0, 32'h0);
    tick();
    tick();
    rst        = 1'b0;
    expRdata   = 32'h0;
    expInstr   = 32'h0;
    expTimeout = 1'b0;
    checkIdle("reset");

    // Fetch with ack after 3 wait cycles; no new cycle afterwards.
    runTxn("fetch", 2'b11, 32'h0000_0040, 32'h0, 3, 32'h0050_0093);
    tick();
    checkIdle("fetch.quiet");

    // Read with ack in the first bus cycle; instr_o stays unchanged.
    runTxn("read", 2'b10, 32'h0000_1000, 32'h0, 0, 32'hCAFE_F00D);

    // Store held across two completions gives two identical writes.
    f0 = fallCount;
    w0 = writeCount;
    applyStimulus(2'b01, 32'h0000_2000, 32'h0000_00AB, 1'b0, 32'h0);
    tick();
    checkBus("store1", 32'h0000_2000, 1'b1, 32'h0000_00AB);
    applyStimulus(2'b01, 32'h0000_2000, 32'h0000_00AB, 1'b1, 32'h0);
    tick();
    checkOutput("store1.done.busy", 32'(busy_o), 32'd0);
    applyStimulus(2'b01, 32'h0000_2000, 32'h0000_00AB, 1'b0, 32'h0);
    tick();
    checkOutput("store1.idle.busy", 32'(bus_cyc_o), 32'd0);
    tick();
    checkBus("store2", 32'h0000_2000, 1'b1, 32'h0000_00AB);
    applyStimulus(2'b00, 32'h0, 32'h0, 1'b1, 32'h0);
    tick();
    applyStimulus(2'b00, 32'h0, 32'h0, 1'b0, 32'h0);
    tick();
    tick();
    checkIdle("store.end");
    checkOutput("store.writes", 32'(writeCount - w0), 32'd2);
    checkOutput("store.falls",  32'(fallCount - f0),  32'd2);

    // Reset during the 5th wait cycle: cycle drops, no data update.
    applyStimulus(2'b10, 32'h0000_3000, 32'h0, 1'b0, 32'h0);
    tick();
    for (int i = 0; i < 4; i++) begin
      applyStimulus(2'b00, 32'h0, 32'h0, 1'b0, 32'h0);
      tick();
    end
    checkBus("rstmid.bus", 32'h0000_3000, 1'b0, 32'h0);
    rst = 1'b1;
    applyStimulus(2'b00, 32'h0, 32'h0, 1'b1, 32'h5555_5555);
    tick();
    rst        = 1'b0;
    expRdata   = 32'h0;
    expInstr   = 32'h0;
    expTimeout = 1'b0;
    applyStimulus(2'b00, 32'h0, 32'h0, 1'b0, 32'h0);
    checkIdle("rstmid");
    tick();
    checkIdle("rstmid.after");

`ifdef T07_MMIO_TIMEOUT_EN
    // Read with no ack: aborted after TO_CYCLES bus cycles with DEADVAL.
    applyStimulus(2'b10, 32'h0000_4000, 32'h0, 1'b0, 32'h0);
    tick();
    for (int i = 1; i < TO_CYCLES; i++) begin
      applyStimulus(2'($urandom), $urandom, $urandom, 1'b0, $urandom);
      tick();
      checkBus("to.wait", 32'h0000_4000, 1'b0, 32'h0);
    end
    applyStimulus(2'b00, 32'h0, 32'h0, 1'b0, 32'h0);
    tick();
    expRdata   = 32'hDEAD_BEEF;
    expTimeout = 1'b1;
    checkIdle("to.done");
    tick();
    checkIdle("to.sticky");
    runTxn("to.next", 2'b11, 32'h0000_4100, 32'h0, 2, 32'h1111_2222);
    rst = 1'b1;
    tick();
    rst        = 1'b0;
    expRdata   = 32'h0;
    expInstr   = 32'h0;
    expTimeout = 1'b0;
    checkIdle("to.rst");

    // Ack in the expiry cycle wins: normal completion, no flag.
    applyStimulus(2'b10, 32'h0000_5000, 32'h0, 1'b0, 32'h0);
    tick();
    for (int i = 1; i < TO_CYCLES; i++) begin
      applyStimulus(2'b00, 32'h0, 32'h0, 1'b0, 32'h0);
      tick();
    end
    checkBus("toack.last", 32'h0000_5000, 1'b0, 32'h0);
    applyStimulus(2'b00, 32'h0, 32'h0, 1'b1, 32'h1234_5678);
    tick();
    expRdata = 32'h1234_5678;
    checkIdle("toack.done");
    applyStimulus(2'b00, 32'h0, 32'h0, 1'b0, 32'h0);
    tick();
`else
    // Without the timeout feature a long wait never aborts.
    runTxn("nowait", 2'b10, 32'h0000_6000, 32'h0, 3 * TO_CYCLES, 32'h0BAD_F00D);
`endif

    // Randomized transactions against the model.
    for (int n = 0; n < 24; n++) begin
      kind  = 2'($urandom_range(1, 3));
      addr  = $urandom;
      wdata = $urandom;
      dat   = $urandom;
      runTxn("rand", kind, addr, wdata, int'($urandom_range(0, 5)), dat);
    end

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule

// File: doc/t07_mmio_sequencer.md
T07_MMIO_SEQUENCER -- requirements
Module: t07_mmio_sequencer

Interface
REQ-001 Parameter TIMEOUT_CYCLES, default 64: bus-cycle abort limit in clocks, used only with T07_MMIO_TIMEOUT_EN.
REQ-002 Parameter DEADVAL, default 32'hDEADBEEF: read/fetch data returned on timeout.
REQ-003 The block SHALL use one clock and a synchronous, active-high reset.
REQ-004 clk  in  1  single clock, rising edge.
REQ-005 rst  in  1  synchronous active-high reset.
REQ-006 rwi_i  in  2  request from memory handler: 00 idle, 01 write, 10 read, 11 fetch.
REQ-007 addr_i  in  32  request byte address.
REQ-008 wdata_i  in  32  write data, already aligned and extended upstream.
REQ-009 busy_o  out  1  high while a bus transaction is outstanding.
REQ-010 rdata_o  out  32  last read data, feeds handler data input.
REQ-011 instr_o  out  32  last fetched instruction, feeds handler instruction input.
REQ-012 bus_cyc_o  out  1  bus cycle/strobe.
REQ-013 bus_we_o  out  1  write enable.
REQ-014 bus_adr_o  out  32  bus address.
REQ-015 bus_dat_o  out  32  bus write data.
REQ-016 bus_sel_o  out  4  byte select, constant 4'b1111.
REQ-017 bus_dat_i  in  32  bus read data, valid with ack.
REQ-018 bus_ack_i  in  1  bus cycle complete.
REQ-019 timeout_o  out  1  sticky timeout flag.

Function
REQ-020 FSM states SHALL be IDLE, BUS, DONE; busy_o = (state==BUS), combinational from registered state.
REQ-021 IDLE with rwi_i!=00 SHALL latch addr_i, wdata_i, we=(rwi_i==01), kind=rwi_i, and go to BUS next cycle; rwi_i==00 stays IDLE.
REQ-022 In BUS, bus_cyc_o=1 and bus_adr_o/bus_dat_o/bus_we_o SHALL be driven from latched values, stable regardless of input changes.
REQ-023 In BUS, bus_ack_i=1 SHALL end the cycle: bus_cyc_o low and state DONE next cycle; an ack in the first BUS cycle is legal.
REQ-024 On ack with kind 10, rdata_o SHALL load bus_dat_i; kind 11 loads instr_o; kind 01 changes neither; unloaded outputs hold.
REQ-025 DONE SHALL last exactly one cycle with busy_o=0, ignore rwi_i, and return to IDLE, so the handler sees one falling busy edge per transaction.
REQ-026 Requests still asserted after DONE SHALL be re-executed as new transactions; no deduplication, so double-edge store handshakes get two identical writes.
REQ-027 Latency: accept in cycle n, bus_cyc_o high from n+1, ack in cycle m>=n+1, busy_o low and data valid in cycle m+1.
REQ-028 rwi_i changes during BUS or DONE SHALL be ignored.
REQ-029 bus_ack_i outside BUS SHALL be ignored.

Reset
REQ-030 rst=1 at a clock edge SHALL force IDLE and zero rdata_o, instr_o, latched address/data, the timeout counter and timeout_o.
REQ-031 Reset mid-transaction SHALL drop bus_cyc_o the next cycle with no data update; busy_o reads 0 after the reset edge.
REQ-032 In reset, bus_cyc_o=0, bus_we_o=0, bus_adr_o=0, bus_dat_o=0, bus_sel_o=4'b1111.

Configuration
REQ-033 With macro T07_MMIO_TIMEOUT_EN defined, a counter SHALL clear on entering BUS and increment each BUS cycle without ack.
REQ-034 With the macro, reaching TIMEOUT_CYCLES without ack SHALL drop bus_cyc_o, go DONE, load DEADVAL into rdata_o (read) or instr_o (fetch), and set timeout_o until reset.
REQ-035 With the macro, ack in the same cycle as expiry SHALL win: normal completion, no flag.
REQ-036 Without the macro, BUS SHALL wait indefinitely for ack and timeout_o SHALL be tied 0; the port remains.

Verification
REQ-037 Fetch: rwi_i=11, addr 0x0000_0040, ack after 3 cycles with dat 0x00500093 -> instr_o=0x00500093, one busy low-pulse, no new cycle while rwi_i returns to 00.
REQ-038 Read: rwi_i=10, addr 0x0000_1000, immediate ack with 0xCAFEF00D -> rdata_o=0xCAFEF00D in cycle m+1, instr_o unchanged.
REQ-039 Store hold: rwi_i=01 held across two completions, wdata 0x000000AB -> two bus writes to same address with bus_we_o=1, two busy falling edges, then idle.
REQ-040 Reset mid-BUS: assert rst during 5th wait cycle -> bus_cyc_o=0 next cycle, rdata_o=0, state IDLE.
REQ-041 Timeout (macro on, TIMEOUT_CYCLES=8): read, no ack -> cyc drops after 8 BUS cycles, rdata_o=0xDEADBEEF, timeout_o=1 until rst.
REQ-042 Ack on expiry cycle (macro on): ack at 8th BUS cycle with 0x12345678 -> rdata_o=0x12345678, timeout_o=0.
